// File: rtl/alu_seq_pkg.sv
// Shared types and field positions for the ALU instruction sequencer.
// Flag capture is built only when ALU_SEQ_FLAGS_EN is defined.
package alu_seq_pkg;

  localparam int DW     = 19;
  localparam int NREG   = 8;
  localparam int AW     = 3;

  localparam int RSV_LSB  = 15;
  localparam int RSV_W    = 4;
  localparam int OPC_LSB  = 10;
  localparam int OPC_W    = 5;
  localparam int MODE_BIT = 9;
  localparam int RD_LSB   = 6;
  localparam int RS1_LSB  = 3;
  localparam int RS2_LSB  = 0;

  localparam int NFLAG   = 5;
  localparam int FLAG_ZA = 4;
  localparam int FLAG_ZB = 3;
  localparam int FLAG_EQ = 2;
  localparam int FLAG_GT = 1;
  localparam int FLAG_LT = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// 8-entry register file: two operand read ports, a debug read port and one
// write port shared by preload and writeback (the two never overlap in time).
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int DW   = 19,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_we_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [DW-1:0] ld_data_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [DW-1:0] wb_data_i,
  input  logic [AW-1:0] rs1_addr_i,
  input  logic [AW-1:0] rs2_addr_i,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [DW-1:0] rs1_data_o,
  output logic [DW-1:0] rs2_data_o,
  output logic [DW-1:0] dbg_data_o
);

  logic [DW-1:0] regs_q [NREG];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  assign wr_en   = ld_we_i | wb_we_i;
  assign wr_addr = wb_we_i ? wb_addr_i : ld_addr_i;
  assign wr_data = wb_we_i ? wb_data_i : ld_data_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign rs1_data_o = regs_q[rs1_addr_i];
  assign rs2_data_o = regs_q[rs2_addr_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Instruction sequencer around an external combinational ALU: fetch operands,
// drive the ALU, capture result/flags, write back. Flags need ALU_SEQ_FLAGS_EN.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int DW   = 19,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  input  logic [DW-1:0] instr,
  output logic          instr_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [4:0]    alu_opcode,
  output logic          alu_mode,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_za,
  input  logic          alu_zb,
  input  logic          alu_eq,
  input  logic          alu_gt,
  input  logic          alu_lt,
  output logic [4:0]    flags,
  output logic          done,
  output logic          err
);

  state_e        state_q, state_d;
  logic [DW-1:0] instr_q;
  logic [DW-1:0] alu_a_q, alu_b_q, res_q;
  logic [4:0]    opc_q;
  logic          mode_q;
  logic [DW-1:0] rs1_data, rs2_data;
  logic          accept, illegal, rf_ld_we, rf_wb_we;

  assign accept  = instr_valid && instr_ready;
  assign illegal = instr_q[RSV_LSB +: RSV_W] != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Illegal instructions pass through READ only to raise err, then drop back.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_READ;
      S_READ:  state_d = illegal ? S_IDLE : S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    rf_wb_we    = 1'b0;
    unique case (state_q)
      S_IDLE:  instr_ready = !ld_valid;
      S_READ:  err = illegal;
      S_WB:    begin done = 1'b1; rf_wb_we = 1'b1; end
      default: ;
    endcase
  end

  assign rf_ld_we = (state_q == S_IDLE) && ld_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      opc_q   <= '0;
      mode_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      if (accept) instr_q <= instr;
      if (state_q == S_READ && !illegal) begin
        alu_a_q <= rs1_data;
        alu_b_q <= rs2_data;
        opc_q   <= instr_q[OPC_LSB +: OPC_W];
        mode_q  <= instr_q[MODE_BIT];
      end
      if (state_q == S_EXEC) res_q <= alu_result;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [NFLAG-1:0] flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (state_q == S_EXEC) begin
      flags_q[FLAG_ZA] <= alu_za;
      flags_q[FLAG_ZB] <= alu_zb;
      flags_q[FLAG_EQ] <= alu_eq;
      flags_q[FLAG_GT] <= alu_gt;
      flags_q[FLAG_LT] <= alu_lt;
    end
  end

  assign flags = flags_q;
`else
  logic unused_alu_flags;
  assign unused_alu_flags = ^{alu_za, alu_zb, alu_eq, alu_gt, alu_lt};
  assign flags = '0;
`endif

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = opc_q;
  assign alu_mode   = mode_q;

  alu_seq_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_we_i    (rf_ld_we),
    .ld_addr_i  (ld_addr),
    .ld_data_i  (ld_data),
    .wb_we_i    (rf_wb_we),
    .wb_addr_i  (instr_q[RD_LSB +: AW]),
    .wb_data_i  (res_q),
    .rs1_addr_i (instr_q[RS1_LSB +: AW]),
    .rs2_addr_i (instr_q[RS2_LSB +: AW]),
    .dbg_addr_i (dbg_addr),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .dbg_data_o (dbg_data)
  );

endmodule
